snake_body: RTL
===============

# snake_body

Movement and body-storage stage for the snake game. It holds the packed head and body coordinates and advances the snake one grid step per movement tick, following the player's direction buttons. It lengthens the snake on request and publishes `snakepos_x`, `snakepos_y` and `length` directly to the collision controller downstream. Segment 0 is the head; segment i occupies bits `[11*i +: 11]`.

## Interface
- `SEGS`, 23: number of stored segments and the maximum length.
- `STEP`, 10: grid pitch in pixels. Every coordinate is a multiple of STEP.
- `H_MAX`, 640: playfield width in pixels. Legal x values are 0 to H_MAX-STEP.
- `V_MAX`, 480: playfield height in pixels. Legal y values are 0 to V_MAX-STEP.
- `START_X`, 320 and `START_Y`, 240: head position at reset.
- `START_LEN`, 2: length at reset. Legal range is 1 to SEGS.
- `MOVE_DIV`, 5_000_000: clock cycles per movement tick. Must be at least 2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: level direction requests, already synchronised.
- `grow` in 1: single-cycle pulse from apple detection.
- `halt` in 1: freezes all movement while high (driven from lose/win).
- `snakepos_x` out 253: packed x coordinates, 23 × 11 bits.
- `snakepos_y` out 253: packed y coordinates, 23 × 11 bits.
- `length` out 6: current segment count.
- `moved` out 1: one-cycle strobe marking a completed step.
- `wall_hit` out 1: sticky flag, set when the head tries to leave the playfield.

## Operation
- Reset values:
  - Segment i < START_LEN: x = START_X − i·STEP, y = START_Y.
  - Segment i ≥ START_LEN: copies of the tail segment (START_LEN−1).
  - `length` = START_LEN, direction = RIGHT, tick counter = 0.
  - `moved` = 0, `wall_hit` = 0, grow-pending = 0.
- Direction register, updated every cycle, with states UP, DOWN, LEFT and RIGHT:
  - When several buttons are pressed, priority is up > down > left > right.
  - A request for the exact opposite of the current direction is ignored.
  - No button pressed leaves the direction unchanged.
- Tick counter:
  - Counts 0 to MOVE_DIV−1 and wraps.
  - A step is attempted on the cycle the counter equals MOVE_DIV−1.
  - While `halt` is high the counter holds its value and no step occurs.
- Step sequence:
  - Compute the new head by adding or subtracting STEP on the axis of the direction register.
  - Shift the body: segment i takes the old segment i−1, for i = 1 to SEGS−1.
  - The head takes the new head value.
- Growth:
  - A `grow` pulse sets grow-pending.
  - At the next step, if length < SEGS, `length` increments by 1. The shift places the old tail at the new last index.
  - Grow-pending clears at that step. Growth saturates at SEGS, and the pending flag still clears.
  - If `grow` arrives in the same cycle as a step, it applies to that step.
  - Multiple grow pulses between steps count once.
- Edge behaviour: see Configuration.

## Timing
- All outputs are registered. Coordinates, `length` and `moved` update together on the clock edge that ends the step cycle.
- Latency from the tick terminal count to the new head on `snakepos_x`/`snakepos_y` is 1 clock.
- `moved` is high for exactly that one cycle. Downstream may sample collisions in the following cycle.
- A direction change takes effect at the next step, provided it was registered at least 1 cycle before the step cycle.
- `halt` asserted in the step cycle suppresses that step.
- `reset` asserted at any time, including mid-step, forces the reset values immediately, independent of `clk`.

## Configuration
- `SNAKE_WRAP_EN` defined: the playfield wraps.
  - Right from x = H_MAX−STEP gives x = 0. Left from x = 0 gives x = H_MAX−STEP.
  - Vertical moves behave the same way with V_MAX.
  - `wall_hit` is tied to 0.
- `SNAKE_WRAP_EN` undefined: a step whose head would leave the playfield is not performed.
  - Positions and length hold, and `moved` stays 0.
  - `wall_hit` sets and stays set until reset.
  - All further steps are suppressed.

## Test plan
- Reset with MOVE_DIV=4, no buttons pressed, 4 steps: the head x sequence is 330, 340, 350, 360 with y = 240. Segment 1 trails by exactly one step, `length` = 2, and `moved` pulses once every 4 cycles.
- While heading right, press `btn_left`: ignored, and the next step is +10 in x. Then press `btn_up` and `btn_left` together: UP wins and the next head y = 230.
- Pulse `grow` 3 times between steps, then step: `length` goes 2→3 and segment 2 equals the old segment 1. Grow in the same cycle as a step: that step's length increments.
- Drive `length` to 23, then pulse `grow` and step: `length` stays 23 and the body shifts normally.
- Head at x = 630 moving right:
  - With `SNAKE_WRAP_EN`: next x = 0.
  - Without it: no move, `wall_hit` = 1, and the head stays at 630 across later ticks.
- Assert `halt` for 10 ticks: no coordinate changes. Assert `reset` in the middle of a step cycle: outputs return immediately to their reset values.

Source files
------------

// File: rtl/snake_body.sv
// Snake movement and body storage: steps the head on each movement tick and shifts the body.
// Define SNAKE_WRAP_EN to make the playfield wrap; by default, leaving the playfield is blocked.
module snake_body #(
    parameter int unsigned SEGS      = 23,
    parameter int unsigned STEP      = 10,
    parameter int unsigned H_MAX     = 640,
    parameter int unsigned V_MAX     = 480,
    parameter int unsigned START_X   = 320,
    parameter int unsigned START_Y   = 240,
    parameter int unsigned START_LEN = 2,
    parameter int unsigned MOVE_DIV  = 5_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               grow,
    input  logic               halt,
    output logic [SEGS*11-1:0] snakepos_x,
    output logic [SEGS*11-1:0] snakepos_y,
    output logic [5:0]         length,
    output logic               moved,
    output logic               wall_hit
);
    localparam int unsigned W  = 11;
    localparam int unsigned PW = SEGS * W;
    localparam int unsigned CW = $clog2(MOVE_DIV);

`ifdef SNAKE_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {DirUp = 2'd0, DirDown = 2'd1, DirLeft = 2'd2, DirRight = 2'd3} dir_e;

    function automatic logic [PW-1:0] init_pos(input bit is_x);
        logic [PW-1:0] v;
        int unsigned   k;
        v = '0;
        for (int unsigned i = 0; i < SEGS; i++) begin
            k = (i < START_LEN) ? i : START_LEN - 1;
            v[i*W +: W] = is_x ? W'(START_X - k * STEP) : W'(START_Y);
        end
        return v;
    endfunction

    localparam logic [PW-1:0] InitX = init_pos(1'b1);
    localparam logic [PW-1:0] InitY = init_pos(1'b0);

    dir_e          dir_q, dir_req;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] x_q, y_q;
    logic [5:0]    len_q;
    logic          moved_q, wall_q, grow_q;
    logic [W-1:0]  cur_x, cur_y, head_x, head_y;
    logic          off_edge, tick, blocked;

    assign cur_x   = x_q[W-1:0];
    assign cur_y   = y_q[W-1:0];
    assign tick    = (cnt_q == CW'(MOVE_DIV - 1)) && !halt;
    assign blocked = !WrapEn && (off_edge || wall_q);

    always_comb begin
        dir_req = dir_q;
        if (btn_up)         dir_req = DirUp;
        else if (btn_down)  dir_req = DirDown;
        else if (btn_left)  dir_req = DirLeft;
        else if (btn_right) dir_req = DirRight;
        if (dir_req == dir_e'(dir_q ^ 2'b01)) dir_req = dir_q;
    end

    // Wrapped values are computed always; without wrap, off_edge blocks the step instead.
    always_comb begin
        head_x   = cur_x;
        head_y   = cur_y;
        off_edge = 1'b0;
        unique case (dir_q)
            DirUp: begin
                off_edge = cur_y < W'(STEP);
                head_y   = off_edge ? W'(V_MAX - STEP) : cur_y - W'(STEP);
            end
            DirDown: begin
                off_edge = cur_y >= W'(V_MAX - STEP);
                head_y   = off_edge ? '0 : cur_y + W'(STEP);
            end
            DirLeft: begin
                off_edge = cur_x < W'(STEP);
                head_x   = off_edge ? W'(H_MAX - STEP) : cur_x - W'(STEP);
            end
            DirRight: begin
                off_edge = cur_x >= W'(H_MAX - STEP);
                head_x   = off_edge ? '0 : cur_x + W'(STEP);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q   <= DirRight;
            cnt_q   <= '0;
            x_q     <= InitX;
            y_q     <= InitY;
            len_q   <= 6'(START_LEN);
            moved_q <= 1'b0;
            wall_q  <= 1'b0;
            grow_q  <= 1'b0;
        end else begin
            dir_q   <= dir_req;
            moved_q <= 1'b0;
            if (!halt) cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (grow) grow_q <= 1'b1;
            if (tick) begin
                if (blocked) begin
                    wall_q <= 1'b1;
                end else begin
                    x_q     <= {x_q[PW-W-1:0], head_x};
                    y_q     <= {y_q[PW-W-1:0], head_y};
                    moved_q <= 1'b1;
                    // A grow in the step cycle counts; the clear wins over the set above.
                    if (grow || grow_q) begin
                        if (len_q < 6'(SEGS)) len_q <= len_q + 6'd1;
                        grow_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign snakepos_x = x_q;
    assign snakepos_y = y_q;
    assign length     = len_q;
    assign moved      = moved_q;
    assign wall_hit   = wall_q;

endmodule
